// File: rtl/program_counter_pkg.sv
// Shared CPU definitions used by the program counter and the jump-condition unit.
// Holds the address width default, the reset vector, the return-stack depth
// default, the jump-code encodings and a helper that sizes the stack pointer.
package program_counter_pkg;

    localparam int unsigned ADDR_W_DEF      = 8;
    localparam int unsigned STACK_DEPTH_DEF = 4;
    localparam int unsigned RESET_VEC       = 0;

    // Jump codes decoded by the jump-condition unit into CE_PC
    typedef enum logic [2:0] {
        JMP_NONE   = 3'd0,
        JMP_ALWAYS = 3'd1,
        JMP_ZERO   = 3'd2,
        JMP_NZERO  = 3'd3,
        JMP_CALL   = 3'd4,
        JMP_RET    = 3'd5
    } jump_code_e;

    // Stack pointer width: must represent 0..depth inclusive
    function automatic int unsigned sp_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/program_counter_if.sv
// Request/status bundle between the core sequencer and the program counter.
// master: drives EN, CE_PC, JMP_ADDR, CALL, RET; observes PC, SP, STACK_ERR.
// slave : the program counter itself.
interface program_counter_if
    import program_counter_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned SP_W   = 3
) ();

    logic              EN;
    logic              CE_PC;
    logic [ADDR_W-1:0] JMP_ADDR;
    logic              CALL;
    logic              RET;
    logic [ADDR_W-1:0] PC;
    logic [SP_W-1:0]   SP;
    logic              STACK_ERR;

    modport master (
        output EN, CE_PC, JMP_ADDR, CALL, RET,
        input  PC, SP, STACK_ERR
    );

    modport slave (
        input  EN, CE_PC, JMP_ADDR, CALL, RET,
        output PC, SP, STACK_ERR
    );

endinterface

// File: rtl/program_counter_return_stack.sv
// return_stack: LIFO of return addresses with saturating stack pointer.
// Ports: CLK, RST (async, active-high), PUSH, POP, DIN, DOUT (top entry,
// 0 when empty), SP (valid entries), FULL, EMPTY.
// PUSH while FULL and POP while EMPTY are ignored; the caller flags misuse.
module return_stack
    import program_counter_pkg::*;
#(
    parameter int unsigned DEPTH = STACK_DEPTH_DEF,
    parameter int unsigned W     = ADDR_W_DEF
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic                       PUSH,
    input  logic                       POP,
    input  logic [W-1:0]               DIN,
    output logic [W-1:0]               DOUT,
    output logic [sp_width(DEPTH)-1:0] SP,
    output logic                       FULL,
    output logic                       EMPTY
);

    localparam int unsigned SP_W  = sp_width(DEPTH);
    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]    mem [DEPTH];
    logic [SP_W-1:0] sp_q;

    assign FULL  = (sp_q == SP_W'(DEPTH));
    assign EMPTY = (sp_q == '0);
    assign SP    = sp_q;
    assign DOUT  = EMPTY ? '0 : mem[IDX_W'(sp_q - SP_W'(1))];

    // Push takes precedence; the caller never asserts both
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sp_q <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else if (PUSH && !FULL) begin
            mem[IDX_W'(sp_q)] <= DIN;
            sp_q              <= sp_q + SP_W'(1);
        end else if (POP && !EMPTY) begin
            sp_q <= sp_q - SP_W'(1);
        end
    end

endmodule

// File: rtl/program_counter.sv
// program_counter: instruction address register with jump load and an
// optional CALL/RET return-address stack.
// Ports: CLK, RST (async, active-high), bus (program_counter_if.slave):
//   EN step enable, CE_PC jump load, JMP_ADDR target, CALL, RET requests,
//   PC current address, SP stack occupancy, STACK_ERR sticky misuse flag.
// Build option: define PC_STACK_EN to include the return stack; without it
// CALL/RET are ignored and SP/STACK_ERR read 0.
module program_counter
    import program_counter_pkg::*;
#(
    parameter int unsigned ADDR_W      = ADDR_W_DEF,
    parameter int unsigned STACK_DEPTH = STACK_DEPTH_DEF,
    parameter int unsigned RESET_ADDR  = RESET_VEC
) (
    input  logic              CLK,
    input  logic              RST,
    program_counter_if.slave  bus
);

    localparam int unsigned SP_W = sp_width(STACK_DEPTH);

    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_d;
    logic [ADDR_W-1:0] pc_inc;

    assign pc_inc = pc_q + ADDR_W'(1);
    assign bus.PC = pc_q;

`ifdef PC_STACK_EN
    logic              err_q;
    logic              err_d;
    logic              push_c;
    logic              pop_c;
    logic [ADDR_W-1:0] top_c;
    logic [SP_W-1:0]   sp_c;
    logic              full_c;
    logic              empty_c;

    return_stack #(
        .DEPTH (STACK_DEPTH),
        .W     (ADDR_W)
    ) u_stack (
        .CLK   (CLK),
        .RST   (RST),
        .PUSH  (push_c),
        .POP   (pop_c),
        .DIN   (pc_inc),
        .DOUT  (top_c),
        .SP    (sp_c),
        .FULL  (full_c),
        .EMPTY (empty_c)
    );

    assign bus.SP        = sp_c;
    assign bus.STACK_ERR = err_q;

    // Priority: illegal CALL&RET, RET, CALL, CE_PC, increment
    always_comb begin
        pc_d   = pc_q;
        err_d  = err_q;
        push_c = 1'b0;
        pop_c  = 1'b0;
        if (bus.EN) begin
            if (bus.CALL && bus.RET) begin
                pc_d  = pc_inc;
                err_d = 1'b1;
            end else if (bus.RET) begin
                if (!empty_c) begin
                    pc_d  = top_c;
                    pop_c = 1'b1;
                end else begin
                    pc_d  = pc_inc;
                    err_d = 1'b1;
                end
            end else if (bus.CALL) begin
                if (!full_c) begin
                    pc_d   = bus.JMP_ADDR;
                    push_c = 1'b1;
                end else begin
                    pc_d  = pc_inc;
                    err_d = 1'b1;
                end
            end else if (bus.CE_PC) begin
                pc_d = bus.JMP_ADDR;
            end else begin
                pc_d = pc_inc;
            end
        end
    end

    // Sticky error, cleared only by reset
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end
`else
    logic unused_req;

    assign unused_req    = bus.CALL ^ bus.RET;
    assign bus.SP        = SP_W'(0);
    assign bus.STACK_ERR = 1'b0;

    // Jump load, else increment
    always_comb begin
        pc_d = pc_q;
        if (bus.EN) begin
            pc_d = bus.CE_PC ? bus.JMP_ADDR : pc_inc;
        end
    end
`endif

    // PC register
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            pc_q <= ADDR_W'(RESET_ADDR);
        end else begin
            pc_q <= pc_d;
        end
    end

endmodule
